bus_memory_target: RTL and testbench

- Bus responder (target) on the shared single-master-at-a-time bus: the other end of the DMA initiator's transactions.
- Decodes begin_transaction cycles addressed to its window and serves single-word or burst reads and byte-enabled writes.
- Backing store is an internal flop-array memory.
- Drives bus outputs only while it owns the current transaction; otherwise all its outputs are 0, so they can be OR-combined with other targets.

---
 rtl/bus_memory_target.sv | 146 ++++++++++++++
 tb/tb_bus_memory_target.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_target.sv
// Bus memory target: decodes its address window and serves single or burst reads
// and byte-enabled writes from an internal flop-array memory.
module bus_memory_target #(
    parameter logic [31:0] Base        = 32'h5000_0000,
    parameter int unsigned AddrWidth   = 4,
    parameter int unsigned ReadLatency = 1,
    parameter int unsigned WriteBusy   = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dataIN,
    input  logic [3:0]  byte_enableIN,
    input  logic [7:0]  burst_sizeIN,
    input  logic        read_n_writeIN,
    input  logic        begin_transactionIN,
    input  logic        end_transactionIN,
    input  logic        data_validIN,
    input  logic        busyIN,
    input  logic        errorIN,
    output logic [31:0] address_dataOUT,
    output logic        end_transactionOUT,
    output logic        data_validOUT,
    output logic        busyOUT,
    output logic        errorOUT
);

    localparam int unsigned Depth  = 1 << AddrWidth;
    localparam int unsigned TagLsb = AddrWidth + 2;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_READ_WAIT = 3'd2;
    localparam logic [2:0] S_READ_DATA = 3'd3;
    localparam logic [2:0] S_READ_END  = 3'd4;
    localparam logic [2:0] S_ERR       = 3'd5;

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [AddrWidth-1:0] ptr;
    logic [8:0]           remaining;
    logic [3:0]           be;
    logic [3:0]           wait_cnt;
    logic [3:0]           busy_cnt;
    logic [31:0]          mem [Depth];

    logic sel_c;
    logic aligned_c;
    logic wr_take_c;
    logic wr_commit_c;
    logic rd_take_c;

    // Transaction strobes; errorIN suppresses every one of them.
    assign sel_c       = (state == S_IDLE) && !errorIN && begin_transactionIN &&
                         (address_dataIN[31:TagLsb] == Base[31:TagLsb]);
    assign aligned_c   = (address_dataIN[1:0] == 2'b00);
    assign wr_take_c   = (state == S_WRITE) && !errorIN && data_validIN && (busy_cnt == 4'd0);
    assign wr_commit_c = wr_take_c && (remaining != 9'd0);
    assign rd_take_c   = (state == S_READ_DATA) && !errorIN && !busyIN;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (errorIN) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_c) begin
                        if (!aligned_c)                state_nxt = S_ERR;
                        else if (!read_n_writeIN)      state_nxt = S_WRITE;
                        else if (ReadLatency <= 1)     state_nxt = S_READ_DATA;
                        else                           state_nxt = S_READ_WAIT;
                    end
                end
                S_WRITE: begin
                    if (wr_take_c && (remaining == 9'd0)) state_nxt = S_ERR;
                    else if (end_transactionIN)           state_nxt = S_IDLE;
                end
                S_READ_WAIT: begin
                    if (wait_cnt <= 4'd1) state_nxt = S_READ_DATA;
                end
                S_READ_DATA: begin
                    if (rd_take_c && (remaining == 9'd0)) state_nxt = S_READ_END;
                end
                S_READ_END: state_nxt = S_IDLE;
                S_ERR:      state_nxt = S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // Pointer, counters and memory; writes keep remaining one ahead so overrun is visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            remaining <= '0;
            be        <= '0;
            wait_cnt  <= '0;
            busy_cnt  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (sel_c && aligned_c) begin
            ptr       <= address_dataIN[TagLsb-1:2];
            remaining <= read_n_writeIN ? {1'b0, burst_sizeIN} : ({1'b0, burst_sizeIN} + 9'd1);
            be        <= byte_enableIN;
            wait_cnt  <= 4'(ReadLatency - 1);
            busy_cnt  <= '0;
        end else if (wr_commit_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[ptr][8*b +: 8] <= address_dataIN[8*b +: 8];
                end
            end
            ptr       <= ptr + AddrWidth'(1);
            remaining <= remaining - 9'd1;
            busy_cnt  <= 4'(WriteBusy);
        end else begin
            if ((state == S_WRITE) && (busy_cnt != 4'd0)) begin
                busy_cnt <= busy_cnt - 4'd1;
            end
            if (state == S_READ_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (rd_take_c && (remaining != 9'd0)) begin
                ptr       <= ptr + AddrWidth'(1);
                remaining <= remaining - 9'd1;
            end
        end
    end

    // Outputs are decoded from state flops and forced to 0 while errorIN is high.
    assign data_validOUT      = (state == S_READ_DATA) && !errorIN;
    assign address_dataOUT    = data_validOUT ? mem[ptr] : 32'd0;
    assign end_transactionOUT = (state == S_READ_END) && !errorIN;
    assign busyOUT            = (state == S_WRITE) && (busy_cnt != 4'd0) && !errorIN;
    assign errorOUT           = (state == S_ERR) && !errorIN;

endmodule

// File: tb/tb_bus_memory_target.sv
// Directed bench for bus_memory_target: two targets on one bus, a per-cycle output
// model derived from transaction-level memory images, plus literal readback checks.
module tb_bus_memory_target;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ad_in;
    logic [3:0]  be_in;
    logic [7:0]  burst_in;
    logic        rnw_in, begin_in, end_in, dv_in, busy_in, err_in;

    logic [31:0] ad_o [2];
    logic        eo [2], dvo [2], bo [2], ero [2];

    always #5 clock = ~clock;

    bus_memory_target #(.Base(32'h5000_0000), .AddrWidth(4), .ReadLatency(1), .WriteBusy(0)) u0 (
        .clock(clock), .reset(reset), .address_dataIN(ad_in), .byte_enableIN(be_in),
        .burst_sizeIN(burst_in), .read_n_writeIN(rnw_in), .begin_transactionIN(begin_in),
        .end_transactionIN(end_in), .data_validIN(dv_in), .busyIN(busy_in), .errorIN(err_in),
        .address_dataOUT(ad_o[0]), .end_transactionOUT(eo[0]), .data_validOUT(dvo[0]),
        .busyOUT(bo[0]), .errorOUT(ero[0]));

    bus_memory_target #(.Base(32'h7000_0000), .AddrWidth(4), .ReadLatency(3), .WriteBusy(2)) u1 (
        .clock(clock), .reset(reset), .address_dataIN(ad_in), .byte_enableIN(be_in),
        .burst_sizeIN(burst_in), .read_n_writeIN(rnw_in), .begin_transactionIN(begin_in),
        .end_transactionIN(end_in), .data_validIN(dv_in), .busyIN(busy_in), .errorIN(err_in),
        .address_dataOUT(ad_o[1]), .end_transactionOUT(eo[1]), .data_validOUT(dvo[1]),
        .busyOUT(bo[1]), .errorOUT(ero[1]));

    int          rl_of [2] = '{1, 3};
    int          wb_of [2] = '{0, 2};
    logic [31:0] mem_m [2][16];
    logic [31:0] e_ad [2];
    logic        e_end [2], e_dv [2], e_busy [2], e_err [2];
    logic [31:0] rdq0 [$];
    logic [31:0] rdq1 [$];
    int          checks = 0;
    int          errors = 0;
    bit          run = 1'b0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    // Compare every output of both targets every cycle; log consumed read words.
    always @(negedge clock) begin
        if (run) begin
            for (int d = 0; d < 2; d++) begin
                chk("address_dataOUT", d, ad_o[d], e_ad[d]);
                chk("end_transactionOUT", d, 32'(eo[d]), 32'(e_end[d]));
                chk("data_validOUT", d, 32'(dvo[d]), 32'(e_dv[d]));
                chk("busyOUT", d, 32'(bo[d]), 32'(e_busy[d]));
                chk("errorOUT", d, 32'(ero[d]), 32'(e_err[d]));
                if (dvo[d] === 1'b1 && !busy_in) begin
                    if (d == 0) rdq0.push_back(ad_o[d]);
                    else        rdq1.push_back(ad_o[d]);
                end
            end
        end
    end

    task automatic next();
        @(posedge clock);
        #1;
        begin_in = 1'b0; ad_in = '0; be_in = '0; burst_in = '0; rnw_in = 1'b0;
        end_in = 1'b0; dv_in = 1'b0; busy_in = 1'b0; err_in = 1'b0;
        for (int d = 0; d < 2; d++) begin
            e_ad[d] = '0; e_end[d] = 1'b0; e_dv[d] = 1'b0; e_busy[d] = 1'b0; e_err[d] = 1'b0;
        end
    endtask

    task automatic pop(input int d, input logic [31:0] exp);
        logic [31:0] v;
        bit ok;
        checks++;
        v = '0;
        ok = (d == 0) ? (rdq0.size() > 0) : (rdq1.size() > 0);
        if (ok) v = (d == 0) ? rdq0.pop_front() : rdq1.pop_front();
        if (!ok) begin
            errors++;
            $display("FAIL readback[%0d] got no word expected %h", d, exp);
        end else if (v !== exp) begin
            errors++;
            $display("FAIL readback[%0d] got %h expected %h", d, v, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) mem_m[d][i] = '0;
    endtask

    task automatic write_txn(input int d, input logic [31:0] addr, input logic [3:0] be, input int burst,
                             input int nwords, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3, input bit with_end,
                             input bit garbage);
        logic [31:0] w [4];
        logic [3:0]  p;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        p = addr[5:2];
        next(); begin_in = 1'b1; ad_in = addr; be_in = be; burst_in = 8'(burst); rnw_in = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            next(); dv_in = 1'b1; ad_in = w[k]; end_in = with_end && (k == nwords - 1);
            if (k > burst) begin
                next(); e_err[d] = 1'b1;
                return;
            end
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[d][p][8*b +: 8] = w[k][8*b +: 8];
            p = p + 4'd1;
            if (!(with_end && k == nwords - 1)) begin
                for (int s = 0; s < wb_of[d]; s++) begin
                    next(); e_busy[d] = 1'b1;
                    if (garbage) begin dv_in = 1'b1; ad_in = 32'hBAD0_0000 | 32'(s); end
                end
            end
        end
    endtask

    task automatic read_txn(input int d, input logic [31:0] addr, input int burst,
                            input int stall_word, input int stall_cycles);
        logic [3:0] p;
        p = addr[5:2];
        next(); begin_in = 1'b1; ad_in = addr; burst_in = 8'(burst); rnw_in = 1'b1; be_in = 4'h0;
        for (int i = 0; i < rl_of[d] - 1; i++) next();
        for (int k = 0; k <= burst; k++) begin
            if (k == stall_word) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    next(); busy_in = 1'b1; e_dv[d] = 1'b1; e_ad[d] = mem_m[d][p];
                end
            end
            next(); e_dv[d] = 1'b1; e_ad[d] = mem_m[d][p];
            p = p + 4'd1;
        end
        next(); e_end[d] = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        clear_model();
        next();
        run = 1'b1;
        next(); next();
        reset = 1'b1;
        next();

        // Single write then single read, latency 1.
        write_txn(0, 32'h5000_0008, 4'hF, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 1'b1, 1'b0);
        read_txn(0, 32'h5000_0008, 0, -1, 0);
        pop(0, 32'hDEAD_BEEF);

        // Byte-lane merge.
        write_txn(0, 32'h5000_000C, 4'hF, 0, 1, 32'h1122_3344, 0, 0, 0, 1'b1, 1'b0);
        write_txn(0, 32'h5000_000C, 4'b0101, 0, 1, 32'hAABB_CCDD, 0, 0, 0, 1'b1, 1'b0);
        read_txn(0, 32'h5000_000C, 0, -1, 0);
        pop(0, 32'h11BB_33DD);

        // Wrapping burst on the latency-3 target with a read stall on the second word.
        write_txn(1, 32'h7000_0038, 4'hF, 3, 4, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 1'b0);
        read_txn(1, 32'h7000_0038, 3, 1, 2);
        pop(1, 32'd1); pop(1, 32'd2); pop(1, 32'd3); pop(1, 32'd4);
        read_txn(1, 32'h7000_0000, 1, -1, 0);
        pop(1, 32'd3); pop(1, 32'd4);

        // Unmapped begin, then misaligned begin followed by data that must be ignored.
        next(); begin_in = 1'b1; ad_in = 32'h6000_0000; rnw_in = 1'b1;
        next(); next(); next();
        next(); begin_in = 1'b1; ad_in = 32'h5000_0002; be_in = 4'hF; rnw_in = 1'b0;
        next(); e_err[0] = 1'b1; dv_in = 1'b1; ad_in = 32'hFFFF_FFFF;
        next(); dv_in = 1'b1; ad_in = 32'hFFFF_FFFF;
        read_txn(0, 32'h5000_0000, 1, -1, 0);
        pop(0, 32'h0); pop(0, 32'h0);

        // Write-busy stalls with dummy words offered, then an overrun word.
        write_txn(1, 32'h7000_0010, 4'hF, 1, 3, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 0, 1'b0, 1'b1);
        next();
        read_txn(1, 32'h7000_0010, 2, -1, 0);
        pop(1, 32'h0A0A_0A0A); pop(1, 32'h0B0B_0B0B); pop(1, 32'h0);

        // errorIN mid read burst, then a clean read.
        next(); begin_in = 1'b1; ad_in = 32'h7000_0038; burst_in = 8'd3; rnw_in = 1'b1;
        next(); next();
        next(); e_dv[1] = 1'b1; e_ad[1] = mem_m[1][14];
        next(); err_in = 1'b1;
        next();
        pop(1, 32'd1);
        read_txn(1, 32'h7000_003C, 0, -1, 0);
        pop(1, 32'd2);

        // errorIN on a write data cycle drops the word.
        next(); begin_in = 1'b1; ad_in = 32'h5000_0010; be_in = 4'hF; rnw_in = 1'b0;
        next(); dv_in = 1'b1; ad_in = 32'h1234_5678; end_in = 1'b1; err_in = 1'b1;
        next();
        read_txn(0, 32'h5000_0010, 0, -1, 0);
        pop(0, 32'h0);

        // Reset mid write clears memory; next transactions complete normally.
        next(); begin_in = 1'b1; ad_in = 32'h5000_0014; be_in = 4'hF; burst_in = 8'd1;
        next(); dv_in = 1'b1; ad_in = 32'h0000_0055;
        next(); dv_in = 1'b1; ad_in = 32'h0000_0066; reset = 1'b0;
        clear_model();
        next(); reset = 1'b1;
        write_txn(0, 32'h5000_0014, 4'hF, 0, 1, 32'h0000_0077, 0, 0, 0, 1'b1, 1'b0);
        read_txn(0, 32'h5000_0008, 3, -1, 0);
        pop(0, 32'h0); pop(0, 32'h0); pop(0, 32'h0); pop(0, 32'h0000_0077);

        next(); next();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
